// File: rtl/plot_pkg.sv
// Shared definitions for the pixel plot path: screen size defaults, queue states,
// colour constants and the packed FIFO entry layout.
package plot_pkg;

  localparam int unsigned WIDTH_DEF  = 160;
  localparam int unsigned HEIGHT_DEF = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLUE  = 3'b001;

  typedef enum logic {
    StRun   = 1'b0,
    StClear = 1'b1
  } plot_state_e;

  // 18-bit FIFO entry; row is truncated to 7 bits to match the adapter.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_entry_t;

  localparam int unsigned EntryBits = $bits(plot_entry_t);

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO for pending plot requests, with a single-cycle flush.
module plot_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A simultaneous pop frees a slot, so a full FIFO can still accept.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/plot_queue.sv
// Buffers single-pixel draw requests and drains them to the VGA plot port;
// also performs a row-major full-screen clear sweep.
module plot_queue
  import plot_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned HEIGHT       = HEIGHT_DEF,
  parameter logic [2:0]  CLEAR_COLOUR = BLACK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_en,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  input  logic       vga_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       overflow,
  output logic       oob
);

  localparam logic [7:0] XLimit = 8'(WIDTH);
  localparam logic [7:0] YLimit = 8'(HEIGHT);
  localparam logic [7:0] XLast  = 8'(WIDTH - 1);
  localparam logic [6:0] YLast  = 7'(HEIGHT - 1);

  plot_state_e state_q, state_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d;
  logic        overflow_q, overflow_d;
  logic        oob_q, oob_d;

  logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  plot_entry_t fifo_wdata, fifo_rdata;
  logic        in_range, req_live;

  assign in_range = (x < XLimit) && (y < YLimit);
  // A clear request from RUN swallows this cycle's draw request silently.
  assign req_live = draw_en && !((state_q == StRun) && clear);

  assign fifo_wdata = '{x: x, y: y[6:0], colour: colour};

  plot_fifo #(
    .DEPTH (DEPTH),
    .DW    (EntryBits)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    overflow_d   = overflow_q;
    oob_d        = oob_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (clear) begin
          fifo_flush = 1'b1;
          cx_d       = '0;
          cy_d       = '0;
          state_d    = StClear;
        end else if (vga_ready && !fifo_empty) begin
          fifo_pop     = 1'b1;
          vga_plot_d   = 1'b1;
          vga_x_d      = fifo_rdata.x;
          vga_y_d      = fifo_rdata.y;
          vga_colour_d = fifo_rdata.colour;
        end
      end
      StClear: begin
        if (vga_ready) begin
          vga_plot_d   = 1'b1;
          vga_x_d      = cx_q;
          vga_y_d      = cy_q;
          vga_colour_d = CLEAR_COLOUR;
          if (cx_q == XLast) begin
            cx_d = '0;
            if (cy_q == YLast) begin
              cy_d    = '0;
              state_d = StRun;
            end else begin
              cy_d = cy_q + 1'b1;
            end
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase

    if (req_live) begin
      if (!in_range) begin
        oob_d = 1'b1;
      end else if (fifo_full && !fifo_pop) begin
        overflow_d = 1'b1;
      end else begin
        fifo_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      cx_q         <= '0;
      cy_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      overflow_q   <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      overflow_q   <= overflow_d;
      oob_q        <= oob_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign overflow   = overflow_q;
  assign oob        = oob_q;
  assign busy       = (state_q == StClear) || !fifo_empty;

endmodule

// File: tb/tb_plot_queue.sv
// Directed bench for plot_queue: latency, overflow, range drops, clear sweep and
// reset mid-clear, all against hand-computed expectations.
module tb_plot_queue;
  import plot_pkg::*;

  logic       clk = 1'b0;
  logic       reset, draw_en, clear, vga_ready;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, overflow, oob;

  int n_checks = 0;
  int n_errors = 0;

  plot_queue #(
    .DEPTH        (4),
    .WIDTH        (160),
    .HEIGHT       (120),
    .CLEAR_COLOUR (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .draw_en    (draw_en),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .clear      (clear),
    .vga_ready  (vga_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .overflow   (overflow),
    .oob        (oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    draw_en = 1'b0;
    clear = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic request(input logic [7:0] rx, input logic [7:0] ry, input logic [2:0] rc);
    draw_en = 1'b1;
    x = rx;
    y = ry;
    colour = rc;
    step();
    draw_en = 1'b0;
  endtask

  logic [7:0] got_x [$];
  logic [6:0] got_y [$];
  logic [2:0] got_c [$];
  int idx, gaps, bad_col, plots;
  bit injected, reclear, got_extra;

  initial begin
    x = '0;
    y = '0;
    colour = '0;
    vga_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_oob", oob, 0);

    // Single request, 2-cycle latency
    vga_ready = 1'b1;
    request(8'd10, 8'd50, RED);
    check("single_wait_plot", vga_plot, 0);
    check("single_wait_busy", busy, 1);
    step();
    check("single_plot", vga_plot, 1);
    check("single_x", vga_x, 10);
    check("single_y", vga_y, 50);
    check("single_colour", vga_colour, 3'b100);
    check("single_busy_low", busy, 0);
    step();
    check("single_one_pulse", vga_plot, 0);
    check("single_x_hold", vga_x, 10);

    // Six requests into a stalled 4-deep queue
    vga_ready = 1'b0;
    for (int i = 0; i < 6; i++) request(8'(20 + i), 8'(30 + i), 3'(i + 1));
    step();
    step();
    check("ovf_flag", overflow, 1);
    check("ovf_oob_clear", oob, 0);
    check("ovf_stalled_plot", vga_plot, 0);
    vga_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (vga_plot) begin
        got_x.push_back(vga_x);
        got_y.push_back(vga_y);
        got_c.push_back(vga_colour);
      end
    end
    check("ovf_plot_count", got_x.size(), 4);
    for (int i = 0; i < 4 && i < got_x.size(); i++) begin
      check($sformatf("ovf_x%0d", i), got_x[i], 20 + i);
      check($sformatf("ovf_y%0d", i), got_y[i], 30 + i);
      check($sformatf("ovf_c%0d", i), got_c[i], i + 1);
    end

    // Out-of-range requests
    do_reset();
    request(8'd160, 8'd50, RED);
    request(8'd10, 8'd120, RED);
    plots = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (vga_plot) plots++;
    end
    check("oob_no_plot", plots, 0);
    check("oob_flag", oob, 1);
    check("oob_ovf_clear", overflow, 0);
    check("oob_busy", busy, 0);

    // Full clear, with a request and a re-clear injected mid-sweep
    do_reset();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_busy", busy, 1);
    idx = 0;
    gaps = 0;
    bad_col = 0;
    injected = 0;
    reclear = 0;
    got_extra = 0;
    for (int c = 0; c < 19400 && !got_extra; c++) begin
      step();
      draw_en = 1'b0;
      clear = 1'b0;
      if (vga_plot) begin
        if (idx < 19200) begin
          if (vga_colour != 3'b000) bad_col++;
          if (idx == 0) begin
            check("clr_first_x", vga_x, 0);
            check("clr_first_y", vga_y, 0);
          end
          if (idx == 160) begin
            check("clr_161_x", vga_x, 0);
            check("clr_161_y", vga_y, 1);
          end
          if (idx == 19199) begin
            check("clr_last_x", vga_x, 159);
            check("clr_last_y", vga_y, 119);
          end
        end else begin
          check("mid_req_x", vga_x, 70);
          check("mid_req_y", vga_y, 50);
          check("mid_req_colour", vga_colour, 3'b001);
          got_extra = 1;
        end
        idx++;
      end else if (idx > 0) begin
        gaps++;
      end
      if (idx == 100 && !injected) begin
        draw_en = 1'b1;
        x = 8'd70;
        y = 8'd50;
        colour = BLUE;
        injected = 1;
      end
      if (idx == 5000 && !reclear) begin
        clear = 1'b1;
        reclear = 1;
      end
    end
    draw_en = 1'b0;
    clear = 1'b0;
    check("clr_total_pulses", idx, 19201);
    check("clr_gaps", gaps, 0);
    check("clr_bad_colour", bad_col, 0);
    step();
    check("clr_done_plot", vga_plot, 0);
    check("clr_done_busy", busy, 0);
    check("clr_done_ovf", overflow, 0);
    check("clr_done_oob", oob, 0);

    // Reset at pixel 500 of a clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    idx = 0;
    for (int c = 0; c < 1000 && idx < 500; c++) begin
      step();
      if (vga_plot) idx++;
    end
    check("rst_mid_reached", idx, 500);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_plot", vga_plot, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_x", vga_x, 0);
    request(8'd33, 8'd44, 3'b010);
    step();
    check("post_rst_plot", vga_plot, 1);
    check("post_rst_x", vga_x, 33);
    check("post_rst_y", vga_y, 44);
    check("post_rst_colour", vga_colour, 3'b010);
    step();
    check("post_rst_idle", vga_plot, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/plot_queue.md
# plot_queue

Buffers single-pixel draw requests from the game state machine and drains them to the VGA adapter plot port, one pixel per accepted cycle. Sits directly downstream of the game FSM's `x`/`y`/`colour`/`draw_en` outputs and directly upstream of the VGA adapter. Also owns full-screen clear: a swept fill of every pixel with a fixed colour, used at game start and restart.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `WIDTH`, 160: screen width in pixels.
- `HEIGHT`, 120: screen height in pixels.
- `CLEAR_COLOUR`, 3'b000: fill colour used by clear.

Ports:
- `clk`  in  1  sole clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `draw_en`  in  1  request strobe, one pixel per high cycle.
- `x`  in  8  request column.
- `y`  in  8  request row.
- `colour`  in  3  request colour {R,G,B}.
- `clear`  in  1  start full-screen clear, sampled per cycle.
- `vga_ready`  in  1  adapter will accept a plot next cycle; tie high for the stock adapter.
- `vga_x`  out  8  plot column (registered).
- `vga_y`  out  7  plot row (registered).
- `vga_colour`  out  3  plot colour (registered).
- `vga_plot`  out  1  plot strobe, one cycle per pixel (registered).
- `busy`  out  1  high while clearing or FIFO non-empty.
- `overflow`  out  1  sticky: request dropped because FIFO full.
- `oob`  out  1  sticky: request dropped because out of range.

## Operation
- Reset: all outputs 0, FIFO empty, state RUN, clear counters 0.
- Accept: `draw_en` high, `x < WIDTH`, `y < HEIGHT`, FIFO not full (or popping this edge) → push {x, y[6:0], colour}.
- Out of range (compare on full 8 bits) → drop, set `oob`. Full with no pop → drop, set `overflow`. Flags clear only on `reset`.
- States: RUN, CLEAR.
- RUN: at each edge with `vga_ready`=1 and FIFO non-empty, pop head; next cycle `vga_plot`=1 with the popped entry on `vga_x/y/colour`. Otherwise `vga_plot`=0; data outputs hold last values.
- RUN, `clear`=1 → flush FIFO (this cycle's request also dropped, no flag), zero cx/cy, go CLEAR.
- CLEAR: each edge with `vga_ready`=1 emits (cx, cy, CLEAR_COLOUR) next cycle; cx increments, wraps WIDTH-1 → 0 with cy increment. Row-major, (0,0) first, (WIDTH-1, HEIGHT-1) last, then RUN on that same edge.
- CLEAR: `clear` ignored (no restart); requests still pushed/flagged normally and drained after return to RUN, in arrival order.
- `vga_ready`=0 pauses drain or sweep with no loss; position held.
- `busy` = (state==CLEAR) | !empty, combinational from registered state.

## Timing
- Empty FIFO, `vga_ready`=1: request sampled at edge N → `vga_plot` high in the cycle after edge N+1 (2-cycle latency).
- Sustained: one pixel per cycle with `vga_ready` held high; push and pop on the same edge both take effect, count unchanged.
- Clear duration: WIDTH×HEIGHT ready cycles (19200 default); first clear pixel is visible the cycle after the first edge in CLEAR with `vga_ready`=1.
- `reset` mid-clear or mid-drain: next cycle outputs 0, FIFO empty, RUN; in-flight pixel is not emitted.

## Structure
- `plot_pkg`: WIDTH/HEIGHT defaults, state enum (RUN, CLEAR), colour constants BLACK=3'b000, RED=3'b100, BLUE=3'b001, shared with the game FSM.
- Sub-module `plot_fifo`: synchronous FIFO, parameter DEPTH, 18-bit entries, push/pop/full/empty, synchronous active-high reset and flush input.
- `plot_queue`: range check, flags, RUN/CLEAR FSM, sweep counters, output registers.

## Test plan
- Reset then single request (10,50,RED), `vga_ready`=1 → one `vga_plot` pulse 2 cycles later with 10/50/3'b100; `busy` falls with the pulse.
- 6 back-to-back requests, `vga_ready`=0 for 8 cycles then 1 → first 4 plotted in order, `overflow`=1, requests 5–6 absent.
- Request (160,50) and (10,120) → no plot, `oob`=1, `overflow`=0.
- `clear` pulse, `vga_ready`=1 → 19200 consecutive pulses with `vga_colour`=0, first (0,0), 161st (0,1), last (159,119), then RUN.
- Request (70,50,BLUE) mid-clear → plotted immediately after (159,119); `clear` re-pulsed mid-sweep has no effect.
- `reset` at pixel 500 of clear → next cycle `vga_plot`=0, `busy`=0, subsequent request plots normally.
